operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Single-entry register-read stage between decode and execute. Reads and consumes the FwCtrl
//  forwarding records from the EXE, MEM and WB stages; produces resolved rs1/rs2 operands.
//  Holds an instruction while a producer is valid but not yet fwdable (load-use or mul/div hazard).
//  Hands operands to EXE over a valid/ready handshake; flushable on redirect or trap.
// PARAMETERS
//  XLEN      64  datapath width (basic::UIntX); also the width of pc
//  STALL_W   32  width of the saturating hazard-stall counter
// PORTS
//  clk           in   1      clock; every register updates on its rising edge
//  rst_n         in   1      asynchronous reset, active low
//  flush         in   1      drop the held entry and the output entry
//  in_valid      in   1      decode offers an instruction
//  in_ready      out  1      stage accepts the offered instruction
//  in_pc         in   XLEN   instruction pc
//  in_inst       in   32     instruction word
//  in_rs1/rs2    in   5 each source register (RegSel)
//  in_use_rs1/2  in   1 each the source register is actually read
//  rf_rs1/rs2    out  5 each register-file read address; combinational read, data returns the same cycle
//  rf_rd1/rd2    in   XLEN   register-file read data
//  fw_{exe,mem,wb}_valid    in  1     forwarding record present
//  fw_{exe,mem,wb}_fwdable  in  1     the wdata of that record is final
//  fw_{exe,mem,wb}_addr     in  5     destination register of that record
//  fw_{exe,mem,wb}_wdata    in  XLEN  write data of that record
//  out_valid     out  1      operands are valid for EXE
//  out_ready     in   1      EXE consumes the output
//  out_pc        out  XLEN   pc of the output instruction
//  out_inst      out  32     instruction word of the output
//  out_op1/op2   out  XLEN   resolved rs1 and rs2 values
//  stall_cnt     out  STALL_W  count of hazard-stall cycles
// BEHAVIOUR
//  Reset values: cur_valid=0, out_valid=0, out_pc/out_inst/out_op1/out_op2=0, stall_cnt=0.
//  Held entry "cur": captured on the edge where in_valid && in_ready is true.
//   in_ready = !cur_valid || advance.
//  Operand resolution (combinational, on cur, for each rs):
//   - !use_rs or rs==0 -> value 0, never a hazard.
//   - Otherwise the first matching record in the order EXE > MEM > WB wins.
//     A record matches when valid && addr==rs.
//   - Winning record fwdable -> its wdata is used.
//   - Winning record !fwdable -> hazard. A lower-priority match is NOT used.
//   - No match -> rf_rd data.
//   - rf_rs1/rf_rs2 are driven from cur at all times.
//  advance = cur_valid && !hazard1 && !hazard2 && (!out_valid || out_ready).
//  On advance: the out_* registers load cur and the resolved operands; out_valid<=1.
//   Minimum latency: accept at edge N -> out_valid at edge N+1.
//  If out_valid && out_ready && !advance: out_valid<=0.
//  While out_valid && !out_ready: all out_* stay stable.
//  Back-to-back: advance and accept in the same cycle give 1 instruction per cycle.
//  stall_cnt: +1 per cycle where cur_valid && (hazard1||hazard2); saturates at all-ones;
//   it is not cleared by flush.
//  flush (highest priority):
//   - next edge: cur_valid<=0 and out_valid<=0;
//   - in_ready is forced to 0 that cycle, so nothing is accepted;
//   - the advance of that cycle is suppressed.
//  Reset asserted mid-handshake clears all state immediately; in_ready=1 after reset.
// TESTING
//  1 add x3 with x1=5, x2=7 in the RF, no fw records -> out_op1=5, out_op2=7 one cycle after accept.
//  2 EXE rec (x1,fwdable,0xAA), MEM rec (x1,fwdable,0xBB) -> out_op1=0xAA, because EXE wins.
//  3 EXE rec (x2,!fwdable) for 3 cycles, then fwdable 0x42:
//    -> stall 3 cycles, in_ready=0, stall_cnt=3, then out_op2=0x42.
//  4 rs1=x0 while EXE rec addr=0 fwdable 0x99 -> out_op1=0; use_rs2=0 and a hazard on rs2 -> no stall.
//  5 out_ready=0 for 4 cycles over a 3-instruction stream:
//    -> out_* frozen, one entry held, in_ready=0; then 1 instr/cycle with no loss or duplication.
//  6 flush in a stall cycle with in_valid=1 -> cycle after: out_valid=0, cur empty,
//    offered instr not taken, stall_cnt kept.

Source files
------------

// File: rtl/operand_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// Module   : operand_fetch_stage_if
// Purpose  : Bundles the decode-side handshake, register-file read port,
//            EXE/MEM/WB forwarding records, the EXE-side handshake and the
//            stall counter of the operand fetch stage.
// Ports    : none (interface); modports
//            slave  - seen from the operand fetch stage
//            master - seen from the surrounding pipeline / testbench
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface operand_fetch_stage_if #(
  parameter int XLEN    = 64,
  parameter int STALL_W = 32
);
  logic               flush;
  // decode side
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_pc;
  logic [31:0]        in_inst;
  logic [4:0]         in_rs1;
  logic [4:0]         in_rs2;
  logic               in_use_rs1;
  logic               in_use_rs2;
  // register file read port
  logic [4:0]         rf_rs1;
  logic [4:0]         rf_rs2;
  logic [XLEN-1:0]    rf_rd1;
  logic [XLEN-1:0]    rf_rd2;
  // forwarding records
  logic               fw_exe_valid;
  logic               fw_exe_fwdable;
  logic [4:0]         fw_exe_addr;
  logic [XLEN-1:0]    fw_exe_wdata;
  logic               fw_mem_valid;
  logic               fw_mem_fwdable;
  logic [4:0]         fw_mem_addr;
  logic [XLEN-1:0]    fw_mem_wdata;
  logic               fw_wb_valid;
  logic               fw_wb_fwdable;
  logic [4:0]         fw_wb_addr;
  logic [XLEN-1:0]    fw_wb_wdata;
  // execute side
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [31:0]        out_inst;
  logic [XLEN-1:0]    out_op1;
  logic [XLEN-1:0]    out_op2;
  logic [STALL_W-1:0] stall_cnt;

  modport slave (
    input  flush,
    input  in_valid, output in_ready, input in_pc, input in_inst,
    input  in_rs1, input in_rs2, input in_use_rs1, input in_use_rs2,
    output rf_rs1, output rf_rs2, input rf_rd1, input rf_rd2,
    input  fw_exe_valid, input fw_exe_fwdable, input fw_exe_addr, input fw_exe_wdata,
    input  fw_mem_valid, input fw_mem_fwdable, input fw_mem_addr, input fw_mem_wdata,
    input  fw_wb_valid,  input fw_wb_fwdable,  input fw_wb_addr,  input fw_wb_wdata,
    output out_valid, input out_ready, output out_pc, output out_inst,
    output out_op1, output out_op2, output stall_cnt
  );

  modport master (
    output flush,
    output in_valid, input in_ready, output in_pc, output in_inst,
    output in_rs1, output in_rs2, output in_use_rs1, output in_use_rs2,
    input  rf_rs1, input rf_rs2, output rf_rd1, output rf_rd2,
    output fw_exe_valid, output fw_exe_fwdable, output fw_exe_addr, output fw_exe_wdata,
    output fw_mem_valid, output fw_mem_fwdable, output fw_mem_addr, output fw_mem_wdata,
    output fw_wb_valid,  output fw_wb_fwdable,  output fw_wb_addr,  output fw_wb_wdata,
    input  out_valid, output out_ready, input out_pc, input out_inst,
    input  out_op1, input out_op2, input stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// Module   : operand_fetch_stage
// Purpose  : Single-entry register-read stage between decode and execute.
//            Resolves rs1/rs2 from the EXE > MEM > WB forwarding records or
//            the register file, holds the instruction while the winning
//            producer is not yet forwardable, and hands the operands to EXE
//            over a valid/ready handshake. Flushable.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous reset, active low
//            bus   - operand_fetch_stage_if.slave (decode handshake, RF read
//                    port, forwarding records, EXE handshake, stall counter)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module operand_fetch_stage #(
  parameter int XLEN    = 64,
  parameter int STALL_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  operand_fetch_stage_if.slave  bus
);

  // Held entry
  logic            cur_valid;
  logic [XLEN-1:0] cur_pc;
  logic [31:0]     cur_inst;
  logic [4:0]      cur_rs1;
  logic [4:0]      cur_rs2;
  logic            cur_use_rs1;
  logic            cur_use_rs2;

  // Output entry
  logic               out_valid;
  logic [XLEN-1:0]    out_pc;
  logic [31:0]        out_inst;
  logic [XLEN-1:0]    out_op1;
  logic [XLEN-1:0]    out_op2;
  logic [STALL_W-1:0] stall_cnt;

  // Forwarding records, index 0 has the highest priority (EXE)
  logic [2:0]           fw_valid;
  logic [2:0]           fw_fwdable;
  logic [2:0][4:0]      fw_addr;
  logic [2:0][XLEN-1:0] fw_wdata;

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            hazard1;
  logic            hazard2;
  logic            advance;
  logic            in_ready;
  logic            accept;

  assign fw_valid   = {bus.fw_wb_valid,   bus.fw_mem_valid,   bus.fw_exe_valid};
  assign fw_fwdable = {bus.fw_wb_fwdable, bus.fw_mem_fwdable, bus.fw_exe_fwdable};
  assign fw_addr    = {bus.fw_wb_addr,    bus.fw_mem_addr,    bus.fw_exe_addr};
  assign fw_wdata   = {bus.fw_wb_wdata,   bus.fw_mem_wdata,   bus.fw_exe_wdata};

  // Returns {hazard, value}. Only the first matching record is consulted:
  // an older value further down the pipe must never shadow a younger
  // producer that is still computing.
  function automatic logic [XLEN:0] resolve(
    input logic                 use_rs,
    input logic [4:0]           rs,
    input logic [XLEN-1:0]      rf_data,
    input logic [2:0]           valid,
    input logic [2:0]           fwdable,
    input logic [2:0][4:0]      addr,
    input logic [2:0][XLEN-1:0] wdata
  );
    logic            hz;
    logic            found;
    logic [XLEN-1:0] val;
    hz    = 1'b0;
    found = 1'b0;
    val   = rf_data;
    if (!use_rs || rs == 5'd0) begin
      val = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!found && valid[i] && addr[i] == rs) begin
          found = 1'b1;
          if (fwdable[i]) val = wdata[i];
          else            hz  = 1'b1;
        end
      end
    end
    return {hz, val};
  endfunction

  always_comb begin
    {hazard1, op1} = resolve(cur_use_rs1, cur_rs1, bus.rf_rd1,
                             fw_valid, fw_fwdable, fw_addr, fw_wdata);
    {hazard2, op2} = resolve(cur_use_rs2, cur_rs2, bus.rf_rd2,
                             fw_valid, fw_fwdable, fw_addr, fw_wdata);
  end

  // Flush suppresses both the hand-off and the acceptance of that cycle.
  assign advance  = !bus.flush && cur_valid && !hazard1 && !hazard2 &&
                    (!out_valid || bus.out_ready);
  assign in_ready = !bus.flush && (!cur_valid || advance);
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_valid   <= 1'b0;
      cur_pc      <= '0;
      cur_inst    <= '0;
      cur_rs1     <= '0;
      cur_rs2     <= '0;
      cur_use_rs1 <= 1'b0;
      cur_use_rs2 <= 1'b0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_inst    <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      stall_cnt   <= '0;
    end else begin
      // held entry
      if (bus.flush) begin
        cur_valid <= 1'b0;
      end else if (accept) begin
        cur_valid   <= 1'b1;
        cur_pc      <= bus.in_pc;
        cur_inst    <= bus.in_inst;
        cur_rs1     <= bus.in_rs1;
        cur_rs2     <= bus.in_rs2;
        cur_use_rs1 <= bus.in_use_rs1;
        cur_use_rs2 <= bus.in_use_rs2;
      end else if (advance) begin
        cur_valid <= 1'b0;
      end

      // output entry
      if (bus.flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        out_valid <= 1'b1;
        out_pc    <= cur_pc;
        out_inst  <= cur_inst;
        out_op1   <= op1;
        out_op2   <= op2;
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end

      // saturating hazard counter, deliberately untouched by flush
      if (cur_valid && (hazard1 || hazard2) && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.rf_rs1    = cur_rs1;
  assign bus.rf_rs2    = cur_rs2;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_pc;
  assign bus.out_inst  = out_inst;
  assign bus.out_op1   = out_op1;
  assign bus.out_op2   = out_op2;
  assign bus.stall_cnt = stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// Module   : tb_operand_fetch_stage
// Purpose  : Directed self-checking bench for operand_fetch_stage.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_operand_fetch_stage;

  localparam int XLEN    = 64;
  localparam int STALL_W = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [XLEN-1:0] regs [32];

  operand_fetch_stage_if #(.XLEN(XLEN), .STALL_W(STALL_W)) bus ();

  operand_fetch_stage #(.XLEN(XLEN), .STALL_W(STALL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // combinational register file model
  assign bus.rf_rd1 = regs[bus.rf_rs1];
  assign bus.rf_rd2 = regs[bus.rf_rs2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2);
    bus.in_valid   = 1'b1;
    bus.in_pc      = pc;
    bus.in_inst    = pc[31:0] ^ 32'h0000_0033;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_use_rs1 = u1;
    bus.in_use_rs2 = u2;
  endtask

  task automatic clear_fw();
    bus.fw_exe_valid = 1'b0; bus.fw_exe_fwdable = 1'b0; bus.fw_exe_addr = '0; bus.fw_exe_wdata = '0;
    bus.fw_mem_valid = 1'b0; bus.fw_mem_fwdable = 1'b0; bus.fw_mem_addr = '0; bus.fw_mem_wdata = '0;
    bus.fw_wb_valid  = 1'b0; bus.fw_wb_fwdable  = 1'b0; bus.fw_wb_addr  = '0; bus.fw_wb_wdata  = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1] = 64'd5;
    regs[2] = 64'd7;
    regs[4] = 64'h44;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_use_rs1 = 1'b0; bus.in_use_rs2 = 1'b0;
    bus.out_ready = 1'b1;
    clear_fw();

    // reset state
    #12;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_op1", bus.out_op1, 64'd0);
    chk("rst_stall", {32'd0, bus.stall_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // 1: plain register-file read, one cycle accept -> out
    offer(64'h100, 5'd1, 5'd2, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_not_yet", {63'd0, bus.out_valid}, 64'd0);
    tick();
    chk("t1_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("t1_op1", bus.out_op1, 64'd5);
    chk("t1_op2", bus.out_op2, 64'd7);
    chk("t1_pc", bus.out_pc, 64'h100);
    chk("t1_inst", {32'd0, bus.out_inst}, 64'h0000_0133);
    tick();
    chk("t1_drain", {63'd0, bus.out_valid}, 64'd0);

    // 2: EXE beats MEM; WB beats register file
    bus.fw_exe_valid = 1'b1; bus.fw_exe_fwdable = 1'b1; bus.fw_exe_addr = 5'd1; bus.fw_exe_wdata = 64'hAA;
    bus.fw_mem_valid = 1'b1; bus.fw_mem_fwdable = 1'b1; bus.fw_mem_addr = 5'd1; bus.fw_mem_wdata = 64'hBB;
    bus.fw_wb_valid  = 1'b1; bus.fw_wb_fwdable  = 1'b1; bus.fw_wb_addr  = 5'd2; bus.fw_wb_wdata  = 64'h66;
    offer(64'h104, 5'd1, 5'd2, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t2_op1_exe", bus.out_op1, 64'hAA);
    chk("t2_op2_wb", bus.out_op2, 64'h66);
    clear_fw();
    tick();

    // 3: EXE not forwardable for three cycles, then 0x42
    bus.fw_exe_valid = 1'b1; bus.fw_exe_fwdable = 1'b0; bus.fw_exe_addr = 5'd2; bus.fw_exe_wdata = 64'h0;
    offer(64'h108, 5'd1, 5'd2, 1'b1, 1'b1);
    tick();
    offer(64'h10C, 5'd1, 5'd1, 1'b1, 1'b1);
    #1;
    chk("t3_in_ready_stall", {63'd0, bus.in_ready}, 64'd0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_held", {63'd0, bus.out_valid}, 64'd0);
    chk("t3_stall_cnt", {32'd0, bus.stall_cnt}, 64'd3);
    bus.fw_exe_fwdable = 1'b1; bus.fw_exe_wdata = 64'h42;
    #1;
    chk("t3_in_ready_go", {63'd0, bus.in_ready}, 64'd1);
    tick();
    chk("t3_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("t3_op1", bus.out_op1, 64'd5);
    chk("t3_op2", bus.out_op2, 64'h42);
    chk("t3_pc", bus.out_pc, 64'h108);
    clear_fw();
    tick();

    // 4: x0 reads zero; unused rs2 hazard does not stall
    bus.fw_exe_valid = 1'b1; bus.fw_exe_fwdable = 1'b1; bus.fw_exe_addr = 5'd0; bus.fw_exe_wdata = 64'h99;
    bus.fw_mem_valid = 1'b1; bus.fw_mem_fwdable = 1'b0; bus.fw_mem_addr = 5'd3;
    offer(64'h110, 5'd0, 5'd3, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t4_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("t4_op1_x0", bus.out_op1, 64'd0);
    chk("t4_op2_unused", bus.out_op2, 64'd0);
    chk("t4_stall_kept", {32'd0, bus.stall_cnt}, 64'd3);
    clear_fw();
    tick();

    // 5: back-pressure over a 3-instruction stream
    bus.out_ready = 1'b0;
    offer(64'h200, 5'd1, 5'd0, 1'b1, 1'b0);
    tick();
    offer(64'h204, 5'd2, 5'd0, 1'b1, 1'b0);
    tick();
    chk("t5_out0_pc", bus.out_pc, 64'h200);
    offer(64'h208, 5'd4, 5'd0, 1'b1, 1'b0);
    #1;
    chk("t5_in_ready_full", {63'd0, bus.in_ready}, 64'd0);
    tick();
    tick();
    chk("t5_frozen_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("t5_frozen_pc", bus.out_pc, 64'h200);
    chk("t5_frozen_op1", bus.out_op1, 64'd5);
    bus.out_ready = 1'b1;
    #1;
    chk("t5_in_ready_drain", {63'd0, bus.in_ready}, 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("t5_out1_pc", bus.out_pc, 64'h204);
    chk("t5_out1_op1", bus.out_op1, 64'd7);
    tick();
    chk("t5_out2_pc", bus.out_pc, 64'h208);
    chk("t5_out2_op1", bus.out_op1, 64'h44);
    tick();
    chk("t5_empty", {63'd0, bus.out_valid}, 64'd0);

    // 6: flush during a stall cycle with a new offer pending
    bus.fw_exe_valid = 1'b1; bus.fw_exe_fwdable = 1'b0; bus.fw_exe_addr = 5'd1;
    offer(64'h300, 5'd1, 5'd0, 1'b1, 1'b0);
    tick();
    offer(64'h304, 5'd2, 5'd0, 1'b1, 1'b0);
    bus.flush = 1'b1;
    #1;
    chk("t6_in_ready_flush", {63'd0, bus.in_ready}, 64'd0);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    clear_fw();
    chk("t6_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("t6_stall_cnt", {32'd0, bus.stall_cnt}, 64'd4);
    #1;
    chk("t6_cur_empty", {63'd0, bus.in_ready}, 64'd1);
    tick();
    chk("t6_nothing_taken", {63'd0, bus.out_valid}, 64'd0);

    // reset while an output is held
    bus.out_ready = 1'b0;
    offer(64'h400, 5'd1, 5'd2, 1'b1, 1'b1);
    tick();
    tick();
    chk("rst2_pre_valid", {63'd0, bus.out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst2_out_pc", bus.out_pc, 64'd0);
    chk("rst2_stall", {32'd0, bus.stall_cnt}, 64'd0);
    chk("rst2_in_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
